// File: rtl/mul6_err_pkg.sv
// Shared widths, FSM state type and stage-1 record for the 6x6 approximate-multiplier error evaluator.
// MUL6_ERR_EVAL_MAXLOC_EN widens the stage-1 record to carry the operands.
package mul6_err_pkg;

   localparam int OP_W      = 6;
   localparam int PROD_W    = 12;
   localparam int ERR_W     = 13;
   localparam int CNT_W     = 13;
   localparam int SUM_ABS_W = 24;
   localparam int SUM_ERR_W = 25;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

`ifdef MUL6_ERR_EVAL_MAXLOC_EN
   typedef struct packed {
      logic                    valid;
      logic signed [ERR_W-1:0] err;
      logic [PROD_W-1:0]       abs_err;
      logic [OP_W-1:0]         op_a;
      logic [OP_W-1:0]         op_b;
   } s1_t;
`else
   typedef struct packed {
      logic                    valid;
      logic signed [ERR_W-1:0] err;
      logic [PROD_W-1:0]       abs_err;
   } s1_t;
`endif

endpackage

// File: rtl/mul6_err_diff.sv
// Stage-1 arithmetic: exact 6x6 product, signed error of the approximate product, and its magnitude.
module mul6_err_diff
   import mul6_err_pkg::*;
(
   input  logic [OP_W-1:0]          op_a_i,
   input  logic [OP_W-1:0]          op_b_i,
   input  logic [PROD_W-1:0]        approx_p_i,
   output logic signed [ERR_W-1:0]  err_o,
   output logic [PROD_W-1:0]        abs_err_o
);

   logic [PROD_W-1:0] exact;

   assign exact = PROD_W'(op_a_i) * PROD_W'(op_b_i);

   // Both products zero-extended by one bit so the difference cannot wrap.
   assign err_o = $signed({1'b0, approx_p_i}) - $signed({1'b0, exact});

   // Worst case magnitudes (4095 and 3969) both fit in the product width.
   assign abs_err_o = err_o[ERR_W-1] ? PROD_W'(-err_o) : err_o[PROD_W-1:0];

endmodule

// File: rtl/mul6_err_eval.sv
// Run controller and error accumulators for an approximate 6x6 multiplier; two-stage pipeline.
// Define MUL6_ERR_EVAL_MAXLOC_EN to add max_a/max_b, the operands that set max_abs_err.
module mul6_err_eval
   import mul6_err_pkg::*;
#(
   parameter int unsigned NUM_SAMPLES = 4096
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [OP_W-1:0]       op_a,
   input  logic [OP_W-1:0]       op_b,
   input  logic [PROD_W-1:0]     approx_p,
   output logic                  busy,
   output logic                  done,
   output logic [CNT_W-1:0]      err_count,
   output logic [SUM_ABS_W-1:0]  sum_abs_err,
   output logic [SUM_ERR_W-1:0]  sum_err,
   output logic [PROD_W-1:0]     max_abs_err
`ifdef MUL6_ERR_EVAL_MAXLOC_EN
   ,
   output logic [OP_W-1:0]       max_a,
   output logic [OP_W-1:0]       max_b
`endif
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SAMPLES - 1);

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    drain_q, drain_d;
   s1_t                     s1_q, s1_d;
   logic [CNT_W-1:0]        err_count_q, err_count_d;
   logic [SUM_ABS_W-1:0]    sum_abs_q, sum_abs_d;
   logic [SUM_ERR_W-1:0]    sum_err_q, sum_err_d;
   logic [PROD_W-1:0]       max_abs_q, max_abs_d;
`ifdef MUL6_ERR_EVAL_MAXLOC_EN
   logic [OP_W-1:0]         max_a_q, max_a_d;
   logic [OP_W-1:0]         max_b_q, max_b_d;
`endif

   logic                    accept;
   logic                    clear;
   logic signed [ERR_W-1:0] diff_err;
   logic [PROD_W-1:0]       diff_abs;

   assign in_ready = (state_q == RUN);
   assign busy     = (state_q == RUN) || (state_q == DRAIN);
   assign done     = (state_q == DONE);
   assign accept   = in_valid && in_ready;

   mul6_err_diff u_diff (
      .op_a_i     (op_a),
      .op_b_i     (op_b),
      .approx_p_i (approx_p),
      .err_o      (diff_err),
      .abs_err_o  (diff_abs)
   );

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      drain_d = drain_q;
      clear   = 1'b0;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = RUN;
               cnt_d   = '0;
               clear   = 1'b1;
            end
         end
         RUN: begin
            if (accept) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_IDX) begin
                  state_d = DRAIN;
                  drain_d = 1'b0;
               end
            end
         end
         DRAIN: begin
            // Two cycles: stage 1 empties, then the accumulators absorb the last sample.
            drain_d = 1'b1;
            if (drain_q) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      s1_d         = '0;
      s1_d.valid   = accept;
      s1_d.err     = diff_err;
      s1_d.abs_err = diff_abs;
`ifdef MUL6_ERR_EVAL_MAXLOC_EN
      s1_d.op_a    = op_a;
      s1_d.op_b    = op_b;
`endif
   end

   always_comb begin
      err_count_d = err_count_q;
      sum_abs_d   = sum_abs_q;
      sum_err_d   = sum_err_q;
      max_abs_d   = max_abs_q;
`ifdef MUL6_ERR_EVAL_MAXLOC_EN
      max_a_d     = max_a_q;
      max_b_d     = max_b_q;
`endif
      if (clear) begin
         err_count_d = '0;
         sum_abs_d   = '0;
         sum_err_d   = '0;
         max_abs_d   = '0;
`ifdef MUL6_ERR_EVAL_MAXLOC_EN
         max_a_d     = '0;
         max_b_d     = '0;
`endif
      end else if (s1_q.valid) begin
         if (s1_q.abs_err != '0) err_count_d = err_count_q + CNT_W'(1);
         sum_abs_d = sum_abs_q + SUM_ABS_W'(s1_q.abs_err);
         sum_err_d = sum_err_q + {{(SUM_ERR_W-ERR_W){s1_q.err[ERR_W-1]}}, s1_q.err};
         // Strictly greater: ties keep the first sample that reached the maximum.
         if (s1_q.abs_err > max_abs_q) begin
            max_abs_d = s1_q.abs_err;
`ifdef MUL6_ERR_EVAL_MAXLOC_EN
            max_a_d   = s1_q.op_a;
            max_b_d   = s1_q.op_b;
`endif
         end
      end
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         drain_q     <= 1'b0;
         s1_q        <= '0;
         err_count_q <= '0;
         sum_abs_q   <= '0;
         sum_err_q   <= '0;
         max_abs_q   <= '0;
`ifdef MUL6_ERR_EVAL_MAXLOC_EN
         max_a_q     <= '0;
         max_b_q     <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         drain_q     <= drain_d;
         s1_q        <= s1_d;
         err_count_q <= err_count_d;
         sum_abs_q   <= sum_abs_d;
         sum_err_q   <= sum_err_d;
         max_abs_q   <= max_abs_d;
`ifdef MUL6_ERR_EVAL_MAXLOC_EN
         max_a_q     <= max_a_d;
         max_b_q     <= max_b_d;
`endif
      end
   end

   assign err_count   = err_count_q;
   assign sum_abs_err = sum_abs_q;
   assign sum_err     = sum_err_q;
   assign max_abs_err = max_abs_q;
`ifdef MUL6_ERR_EVAL_MAXLOC_EN
   assign max_a       = max_a_q;
   assign max_b       = max_b_q;
`endif

endmodule

// File: tb/tb_mul6_err_eval.sv
// Self-checking bench for mul6_err_eval: three instances (1, 200, 4096 samples) against a queue-based model.
`timescale 1ns/1ps
module tb_mul6_err_eval;

   localparam int NI = 3;

   function automatic int ns_of(input int i);
      return (i == 0) ? 1 : ((i == 1) ? 200 : 4096);
   endfunction

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic [5:0]  op_a = '0;
   logic [5:0]  op_b = '0;
   logic [11:0] approx_p = '0;

   logic        start_v [NI];
   logic        rdy     [NI];
   logic        bsy     [NI];
   logic        dn      [NI];
   logic [12:0] ecnt    [NI];
   logic [23:0] sabs    [NI];
   logic [24:0] serr    [NI];
   logic [11:0] mx      [NI];
`ifdef MUL6_ERR_EVAL_MAXLOC_EN
   logic [5:0]  mxa     [NI];
   logic [5:0]  mxb     [NI];
`endif

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      mul6_err_eval #(.NUM_SAMPLES((g == 0) ? 1 : ((g == 1) ? 200 : 4096))) u_dut (
         .clk         (clk),
         .rst_n       (rst_n),
         .start       (start_v[g]),
         .in_valid    (in_valid),
         .in_ready    (rdy[g]),
         .op_a        (op_a),
         .op_b        (op_b),
         .approx_p    (approx_p),
         .busy        (bsy[g]),
         .done        (dn[g]),
         .err_count   (ecnt[g]),
         .sum_abs_err (sabs[g]),
         .sum_err     (serr[g]),
         .max_abs_err (mx[g])
`ifdef MUL6_ERR_EVAL_MAXLOC_EN
         ,
         .max_a       (mxa[g]),
         .max_b       (mxb[g])
`endif
      );
   end

   typedef struct {
      int a;
      int b;
      int p;
   } smp_t;

   smp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Sample generators: 0 exact sweep, 1 LSB-cleared sweep, 2 random, 3 tie pattern, 4 single fixed.
   task automatic gen_sample(input int mode, input int idx, output int a, output int b, output int p);
      int d;
      a = $urandom_range(63);
      b = $urandom_range(63);
      p = a * b;
      case (mode)
         0: begin a = idx / 64; b = idx % 64; p = a * b; end
         1: begin a = idx / 64; b = idx % 64; p = (a * b) & ~1; end
         2: begin
            case ($urandom_range(2))
               0: p = a * b;
               1: begin
                  d = $urandom_range(16) - 8;
                  p = a * b + d;
                  if (p < 0) p = 0;
                  if (p > 4095) p = 4095;
               end
               default: p = $urandom_range(4095);
            endcase
         end
         3: begin
            if (idx == 0) begin a = 2; b = 2; p = 0; end
            else if (idx == 1) begin a = 1; b = 4; p = 0; end
         end
         default: begin a = 3; b = 5; p = 14; end
      endcase
   endtask

   task automatic check_results(input int sel, input string tag);
      longint e_cnt = 0, e_abs = 0, e_sum = 0, e_max = 0;
      int e_a = 0, e_b = 0;
      foreach (q[i]) begin
         longint e  = longint'(q[i].p) - longint'(q[i].a * q[i].b);
         longint ae = (e < 0) ? -e : e;
         if (e != 0) e_cnt++;
         e_abs += ae;
         e_sum += e;
         if (ae > e_max) begin
            e_max = ae;
            e_a   = q[i].a;
            e_b   = q[i].b;
         end
      end
      check({tag, " err_count"},   ecnt[sel], e_cnt);
      check({tag, " sum_abs_err"}, sabs[sel], e_abs);
      check({tag, " sum_err"},     $signed(serr[sel]), e_sum);
      check({tag, " max_abs_err"}, mx[sel], e_max);
`ifdef MUL6_ERR_EVAL_MAXLOC_EN
      check({tag, " max_a"}, mxa[sel], e_a);
      check({tag, " max_b"}, mxb[sel], e_b);
`else
      if (e_a < 0 || e_b < 0) check({tag, " maxloc"}, 0, 1);
`endif
   endtask

   task automatic pulse_start(input int sel);
      @(negedge clk);
      start_v[sel] = 1'b1;
      in_valid     = 1'b0;
      @(negedge clk);
      start_v[sel] = 1'b0;
   endtask

   task automatic run_test(input int sel, input int mode, input int vprob, input int start_at, input string tag);
      int n      = ns_of(sel);
      int budget = n * 20 + 100;
      int acc    = 0;
      int cyc    = 0;
      int a, b, p;
      logic v;
      smp_t s;
      q.delete();
      pulse_start(sel);
      check({tag, " busy after start"}, bsy[sel], 1);
      while (acc < n && cyc < budget) begin
         v = ($urandom_range(99) < vprob);
         gen_sample(mode, acc, a, b, p);
         check({tag, " in_ready in run"}, rdy[sel], 1);
         if (rdy[sel] !== 1'b1) break;
         in_valid     = v;
         op_a         = a[5:0];
         op_b         = b[5:0];
         approx_p     = p[11:0];
         start_v[sel] = (cyc == start_at);
         if (v) begin
            s.a = a; s.b = b; s.p = p;
            q.push_back(s);
            acc++;
         end
         @(negedge clk);
         cyc++;
      end
      start_v[sel] = 1'b0;
      if (acc < n) check({tag, " accepted within budget"}, acc, n);
      // Keep offering samples through DRAIN and DONE; none may be taken.
      in_valid = 1'b1;
      op_a     = 6'd63;
      op_b     = 6'd63;
      approx_p = 12'd0;
      check({tag, " ready t+1"}, rdy[sel], 0);
      check({tag, " busy t+1"},  bsy[sel], 1);
      check({tag, " done t+1"},  dn[sel],  0);
      @(negedge clk);
      check({tag, " busy t+2"},  bsy[sel], 1);
      check({tag, " done t+2"},  dn[sel],  0);
      @(negedge clk);
      check({tag, " done t+3"},  dn[sel],  1);
      check({tag, " busy t+3"},  bsy[sel], 0);
      check({tag, " ready t+3"}, rdy[sel], 0);
      repeat (3) @(negedge clk);
      check({tag, " done held"}, dn[sel],  1);
      in_valid = 1'b0;
      check_results(sel, tag);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int a, b, p;
      smp_t s;
      for (int i = 0; i < NI; i++) start_v[i] = 1'b0;

      #2 rst_n = 1'b0;
      #1;
      for (int i = 0; i < NI; i++) begin
         check($sformatf("reset[%0d] in_ready", i), rdy[i], 0);
         check($sformatf("reset[%0d] busy", i),     bsy[i], 0);
         check($sformatf("reset[%0d] done", i),     dn[i],  0);
         check($sformatf("reset[%0d] err_count", i), ecnt[i], 0);
         check($sformatf("reset[%0d] sum_err", i),  serr[i], 0);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      in_valid = 1'b1;
      repeat (3) @(negedge clk);
      check("idle after reset in_ready", rdy[1], 0);
      check("idle after reset busy",     bsy[1], 0);
      in_valid = 1'b0;

      run_test(0, 4, 100, -1, "single");
      check("single err_count const",   ecnt[0], 1);
      check("single sum_abs_err const", sabs[0], 1);
      check("single sum_err const",     $signed(serr[0]), -1);
      check("single max_abs_err const", mx[0], 1);

      run_test(2, 0, 100, -1, "exact");
      check("exact err_count const",   ecnt[2], 0);
      check("exact sum_abs_err const", sabs[2], 0);
      check("exact max_abs_err const", mx[2], 0);

      run_test(2, 1, 100, -1, "lsb");
      check("lsb err_count const",   ecnt[2], 1024);
      check("lsb sum_abs_err const", sabs[2], 1024);
      check("lsb sum_err const",     $signed(serr[2]), -1024);
      check("lsb max_abs_err const", mx[2], 1);

      run_test(1, 3, 100, -1, "tie");
      check("tie max_abs_err const", mx[1], 4);
`ifdef MUL6_ERR_EVAL_MAXLOC_EN
      check("tie max_a const", mxa[1], 2);
      check("tie max_b const", mxb[1], 2);
`endif

      run_test(1, 2, 60, -1, "bp60");
      run_test(1, 2, 30, -1, "bp30");
      repeat (10) @(negedge clk);
      check_results(1, "done hold");

      // Reset in the middle of a run, after 100 accepted samples.
      pulse_start(1);
      for (int i = 0; i < 100; i++) begin
         gen_sample(2, i, a, b, p);
         in_valid = 1'b1;
         op_a     = a[5:0];
         op_b     = b[5:0];
         approx_p = p[11:0];
         @(negedge clk);
      end
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("midreset in_ready",    rdy[1],  0);
      check("midreset busy",        bsy[1],  0);
      check("midreset done",        dn[1],   0);
      check("midreset err_count",   ecnt[1], 0);
      check("midreset sum_abs_err", sabs[1], 0);
      check("midreset sum_err",     serr[1], 0);
      check("midreset max_abs_err", mx[1],   0);
      repeat (2) @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 1'b1;
      approx_p = 12'd0;
      op_a     = 6'd7;
      op_b     = 6'd9;
      repeat (3) @(negedge clk);
      check("post-reset waits in_ready", rdy[1],  0);
      check("post-reset waits busy",     bsy[1],  0);
      check("post-reset no accept",      ecnt[1], 0);
      in_valid = 1'b0;

      run_test(1, 2, 80, 50, "rerun start-in-run");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mul6_err_eval.md
MUL6_ERR_EVAL -- requirements
Module: mul6_err_eval

Interface
REQ-001 The block SHALL have parameter NUM_SAMPLES, default 4096, giving the samples per run (legal 1..4096).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: a one-cycle pulse that begins a run.
REQ-005 The block SHALL have port in_valid, input, 1 bit: a sample is presented.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts the presented sample.
REQ-007 The block SHALL have ports op_a and op_b, input, 6 bits each: unsigned multiplier operands.
REQ-008 The block SHALL have port approx_p, input, 12 bits: the approximate multiplier product for op_a and op_b.
REQ-009 The block SHALL have ports busy and done, output, 1 bit each: run in progress, and run complete.
REQ-010 The block SHALL have port err_count, output, 13 bits: number of samples with a nonzero error.
REQ-011 The block SHALL have port sum_abs_err, output, 24 bits: sum of |approx_p - exact|.
REQ-012 The block SHALL have port sum_err, output, 25 bits two's complement: sum of (approx_p - exact).
REQ-013 The block SHALL have port max_abs_err, output, 12 bits: largest |error| seen in the run.

Function
REQ-014 A sample SHALL be accepted only in a cycle where in_valid and in_ready are both high.
REQ-015 The block SHALL compute exact as op_a*op_b, 12 bits unsigned, and err as approx_p - exact, 13 bits signed.
REQ-016 The pipeline SHALL be two stages: stage 1 registers err and |err|; stage 2 updates the accumulators.
REQ-017 The accumulators SHALL reflect a sample accepted in cycle t from cycle t+2 onward.
REQ-018 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-019 IDLE SHALL go to RUN on start, clearing the accumulators and the sample counter in that same cycle.
REQ-020 RUN SHALL go to DRAIN on acceptance of sample number NUM_SAMPLES.
REQ-021 DRAIN SHALL go to DONE once the pipeline is empty, which takes 2 cycles.
REQ-022 DONE SHALL go to RUN on start, clearing the accumulators and the sample counter; otherwise DONE SHALL hold.
REQ-023 in_ready SHALL be 1 only in RUN.
REQ-024 busy SHALL be 1 in RUN and DRAIN.
REQ-025 done SHALL be 1 only in DONE, held as a level.
REQ-026 start SHALL be ignored in RUN and DRAIN.
REQ-027 max_abs_err SHALL update only on a strictly greater value, so ties keep the first occurrence.
REQ-028 The accumulator widths SHALL not overflow for NUM_SAMPLES ≤ 4096; no saturation logic is required.
REQ-029 The accumulator outputs SHALL hold their values in DONE and IDLE until the next start.

Reset
REQ-030 Asserting rst_n low SHALL immediately force state to IDLE and set every output and counter to 0, with in_ready, busy and done all 0.
REQ-031 Reset mid-run SHALL discard all in-flight samples.
REQ-032 After rst_n deasserts, the block SHALL wait for a new start before accepting samples.

Configuration
REQ-033 With MUL6_ERR_EVAL_MAXLOC_EN defined, the block SHALL add outputs max_a and max_b (6 bits each) holding the operands of the sample that set max_abs_err; they reset to 0 and clear on start.
REQ-034 Without MUL6_ERR_EVAL_MAXLOC_EN, those ports and their registers SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-035 A shared package mul6_err_pkg SHALL hold the operand width (6), product width (12), error width (13), the accumulator widths and the FSM state enum.
REQ-036 One sub-module, mul6_err_diff, SHALL hold the stage-1 exact-product, signed-difference and absolute-value logic; the FSM and accumulators SHALL stay in the top module.

Verification
REQ-037 Single sample: NUM_SAMPLES=1, a=3, b=5, approx_p=14 -> done 3 cycles after acceptance; err_count=1, sum_abs_err=1, sum_err=-1, max_abs_err=1.
REQ-038 Exhaustive exact: 4096 samples with approx_p=a*b -> err_count=0, sum_abs_err=0, sum_err=0, max_abs_err=0.
REQ-039 Exhaustive LSB-cleared: approx_p = (a*b) with bit 0 forced to 0 -> err_count=1024, sum_abs_err=1024, sum_err=-1024, max_abs_err=1.
REQ-040 Backpressure: random in_valid gaps, and samples offered in DRAIN/DONE -> only NUM_SAMPLES samples are accepted, and the results match the reference model.
REQ-041 Tie and maxloc: samples (2,2,approx 0) then (1,4,approx 0) -> max_abs_err=4, and with the macro defined max_a=2, max_b=2.
REQ-042 Reset mid-run: rst_n low after 100 samples, then start and a full run -> outputs equal a clean run; start pulsed during RUN -> no effect.
